// File: rtl/mac_seq_pkg.sv
// Shared types and helpers for the MAC dot-product sequencer.
package mac_seq_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_PROD_W = 32;
    localparam int DEF_SUM_W  = 40;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_GAP,
        S_ISSUE,
        S_WAIT,
        S_OUT
    } state_e;

    // Unsigned distance between a MAC result and the exact product.
    function automatic logic [DEF_PROD_W-1:0] abs_diff(input logic [DEF_PROD_W-1:0] x,
                                                       input logic [DEF_PROD_W-1:0] y);
        return (x > y) ? (x - y) : (y - x);
    endfunction

endpackage

// File: rtl/mac_seq_fifo.sv
// Synchronous operand FIFO with combinational head read and async active-high reset.
module mac_seq_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/mac_dot_sequencer.sv
// Drives an approximate MAC once per buffered operand pair and accumulates
// approximate and exact dot products plus error statistics per vector.
module mac_dot_sequencer
    import mac_seq_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int PROD_W     = DEF_PROD_W,
    parameter int SUM_W      = DEF_SUM_W,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1000,
    parameter int ERR_TOL    = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_last,
    output logic              mac_rst,
    output logic              mac_start,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    input  logic              mac_done,
    input  logic [PROD_W-1:0] mac_acc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SUM_W-1:0]  out_sum,
    output logic [SUM_W-1:0]  out_exact,
    output logic [PROD_W-1:0] out_max_err,
    output logic [15:0]       out_fail_cnt,
    output logic              out_timeout
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int FW    = 2 * DATA_W + 1;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SUM_W-1:0]  sum_q, sum_d, exact_q, exact_d;
    logic [PROD_W-1:0] max_err_q, max_err_d;
    logic [15:0]       fail_q, fail_d, fail_inc;
    logic              tmo_q, tmo_d;
    logic              ready_en_q;

    logic              fifo_full, fifo_empty, push, pop;
    logic [FW-1:0]     head;
    logic [PROD_W-1:0] prod, err;

    // in_ready stays low through reset and rises on the first clock after it.
    assign in_ready = ready_en_q && !fifo_full;
    assign push     = in_valid && in_ready;
    assign prod     = PROD_W'(a_q) * PROD_W'(b_q);
    assign err      = abs_diff(mac_acc, prod);
    assign fail_inc = (fail_q == 16'hFFFF) ? fail_q : fail_q + 16'd1;

    mac_seq_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i ({in_a, in_b, in_last}),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        exact_d   = exact_q;
        max_err_d = max_err_q;
        fail_d    = fail_q;
        tmo_d     = tmo_q;
        pop       = 1'b0;
        mac_rst   = 1'b0;
        mac_start = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    {a_d, b_d, last_d} = head;
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                mac_rst = 1'b1;
                state_d = S_GAP;
            end
            S_GAP: state_d = S_ISSUE;
            S_ISSUE: begin
                mac_start = 1'b1;
                cnt_d     = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (mac_done) begin
                    sum_d   = sum_q + SUM_W'(mac_acc);
                    exact_d = exact_q + SUM_W'(prod);
                    if (err > max_err_q)           max_err_d = err;
                    if (err > PROD_W'(ERR_TOL))    fail_d    = fail_inc;
                    state_d = last_q ? S_OUT : S_IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Abandoned pair: only the exact sum still sees it.
                    exact_d = exact_q + SUM_W'(prod);
                    tmo_d   = 1'b1;
                    fail_d  = fail_inc;
                    state_d = last_q ? S_OUT : S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    sum_d     = '0;
                    exact_d   = '0;
                    max_err_d = '0;
                    fail_d    = '0;
                    tmo_d     = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            last_q     <= 1'b0;
            cnt_q      <= '0;
            sum_q      <= '0;
            exact_q    <= '0;
            max_err_q  <= '0;
            fail_q     <= '0;
            tmo_q      <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            exact_q    <= exact_d;
            max_err_q  <= max_err_d;
            fail_q     <= fail_d;
            tmo_q      <= tmo_d;
            ready_en_q <= 1'b1;
        end
    end

    assign mac_a        = a_q;
    assign mac_b        = b_q;
    assign out_sum      = sum_q;
    assign out_exact    = exact_q;
    assign out_max_err  = max_err_q;
    assign out_fail_cnt = fail_q;
    assign out_timeout  = tmo_q;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Self-checking bench: behavioural MAC responder plus an arithmetic reference
// model of the per-vector frame, with randomized and directed scenarios.
module tb_mac_dot_sequencer;

    localparam int TIMEOUT = 1000;

    logic        clk, rst;
    logic        in_valid, in_ready, in_last;
    logic [15:0] in_a, in_b;
    logic        mac_rst, mac_start, mac_done;
    logic [15:0] mac_a, mac_b;
    logic [31:0] mac_acc;
    logic        out_valid, out_ready, out_timeout;
    logic [39:0] out_sum, out_exact;
    logic [31:0] out_max_err;
    logic [15:0] out_fail_cnt;

    typedef struct packed {
        logic [39:0] sum;
        logic [39:0] exact;
        logic [31:0] max_err;
        logic [15:0] fail_cnt;
        logic        tmo;
    } frame_t;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // MAC responder knobs
    int mac_lat   = 0;
    int err_mode  = 0;
    int err_off   = 0;
    bit mac_never = 0;

    mac_dot_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_last      (in_last),
        .mac_rst      (mac_rst),
        .mac_start    (mac_start),
        .mac_a        (mac_a),
        .mac_b        (mac_b),
        .mac_done     (mac_done),
        .mac_acc      (mac_acc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_exact    (out_exact),
        .out_max_err  (out_max_err),
        .out_fail_cnt (out_fail_cnt),
        .out_timeout  (out_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Error the approximate MAC adds to a*b for a given pair.
    function automatic int delta(input int unsigned a, input int unsigned b);
        case (err_mode)
            0:       return 0;
            1:       return err_off;
            default: return int'((a ^ b) & 31) - 16;
        endcase
    endfunction

    // Behavioural MAC plus handshake-order monitor, both evaluated on the falling edge.
    bit          busy = 0;
    int          cd   = 0;
    logic [15:0] ma, mb;
    logic        h1_rst = 0, h1_start = 0, h2_rst = 0;
    int          n_start = 0;
    int          seq_bad = 0;

    always @(negedge clk) begin
        mac_done = 1'b0;
        if (rst) begin
            busy    = 0;
            mac_acc = '0;
        end else begin
            if (busy) begin
                if (cd == 0) begin
                    mac_done = 1'b1;
                    mac_acc  = 32'(longint'(ma) * longint'(mb) + longint'(delta(ma, mb)));
                    busy     = 0;
                end else begin
                    cd--;
                end
            end
            if (mac_start) begin
                n_start++;
                if (!(h2_rst && !h1_rst && !h1_start) || mac_rst) seq_bad++;
                if (!mac_never) begin
                    busy = 1;
                    cd   = mac_lat;
                    ma   = mac_a;
                    mb   = mac_b;
                end
            end
        end
        h2_rst   = h1_rst;
        h1_rst   = mac_rst;
        h1_start = mac_start;
    end

    // Reference frame for one vector, straight from the accumulation rules.
    function automatic frame_t model(input int unsigned va[$], input int unsigned vb[$], input bit never);
        frame_t f;
        longint s = 0, e = 0, m = 0, p, acc, er;
        int     fc = 0;
        f = '0;
        foreach (va[i]) begin
            p = longint'(va[i]) * longint'(vb[i]);
            e = e + p;
            if (never) begin
                fc++;
                f.tmo = 1'b1;
            end else begin
                acc = (p + longint'(delta(va[i], vb[i]))) & 64'hFFFF_FFFF;
                s   = s + acc;
                er  = (acc > p) ? acc - p : p - acc;
                if (er > m) m = er;
                if (er > 12) fc++;
            end
        end
        f.sum      = 40'(s);
        f.exact    = 40'(e);
        f.max_err  = 32'(m);
        f.fail_cnt = (fc > 65535) ? 16'hFFFF : 16'(fc);
        return f;
    endfunction

    task automatic push_one(input int unsigned a, input int unsigned b, input bit last);
        int t = 0;
        in_valid = 1'b1;
        in_a     = 16'(a);
        in_b     = 16'(b);
        in_last  = last;
        while (!in_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL push_wait: in_ready=0 after %0d cycles, required 1", t);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic push_vec(input int unsigned va[$], input int unsigned vb[$]);
        foreach (va[i]) push_one(va[i], vb[i], i == va.size() - 1);
    endtask

    // Waits (bounded) for a frame, holds it for a while, samples it, then accepts it.
    task automatic get_frame(output frame_t f, input int budget, input int hold);
        int t = 0;
        while (!out_valid && t < budget) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!out_valid) begin
            failures++;
            $display("FAIL frame_wait: out_valid=0 after %0d cycles, required 1", budget);
        end
        repeat (hold) @(negedge clk);
        f = '{out_sum, out_exact, out_max_err, out_fail_cnt, out_timeout};
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if ({in_ready, mac_rst, mac_start, mac_a, mac_b, out_valid, out_sum, out_exact,
             out_max_err, out_fail_cnt, out_timeout} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got ready=%b valid=%b sum=%h, required all zero",
                     in_ready, out_valid, out_sum);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready_rise: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_exact;
        int unsigned va[$] = '{3, 5, 7};
        int unsigned vb[$] = '{4, 6, 8};
        frame_t got, exp;
        int n0 = n_start;
        err_mode = 0;
        mac_lat  = 2;
        exp = model(va, vb, 0);
        push_vec(va, vb);
        get_frame(got, 200, 0);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL exact_vec: got %p required %p", got, exp);
        end
        checks++;
        if (seq_bad != 0 || n_start - n0 != 3) begin
            failures++;
            $display("FAIL mac_sequence: bad_orders=%0d starts=%0d, required 0 and 3", seq_bad, n_start - n0);
        end
    endtask

    task automatic test_error;
        int unsigned va[$] = '{15};
        int unsigned vb[$] = '{15};
        frame_t got, exp;
        err_mode = 1;
        mac_lat  = 0;
        for (int k = 0; k < 2; k++) begin
            err_off = (k == 0) ? 10 : 13;
            exp = model(va, vb, 0);
            push_vec(va, vb);
            get_frame(got, 200, 1);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL error_off%0d: got %p required %p", err_off, got, exp);
            end
        end
    endtask

    task automatic test_timeout;
        int unsigned va[$] = '{2};
        int unsigned vb[$] = '{2};
        frame_t got, exp;
        int t = 0;
        int c1, c2;
        mac_never = 1;
        err_mode  = 0;
        exp = model(va, vb, 1);
        push_vec(va, vb);
        while (!mac_rst && t < 50) begin
            @(negedge clk);
            t++;
        end
        c1 = cyc;
        t  = 0;
        while (!out_valid && t < TIMEOUT + 100) begin
            @(negedge clk);
            t++;
        end
        c2 = cyc;
        checks++;
        if (c2 - c1 != TIMEOUT + 3) begin
            failures++;
            $display("FAIL timeout_latency: clear-to-valid=%0d cycles, required %0d", c2 - c1, TIMEOUT + 3);
        end
        get_frame(got, 10, 0);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL timeout_frame: got %p required %p", got, exp);
        end
        mac_never = 0;
    endtask

    task automatic test_stall;
        int unsigned v1a[$], v1b[$], v2a[$], v2b[$];
        frame_t g1, g2, e1, e2;
        int t  = 0;
        int n0 = n_start;
        err_mode = 2;
        mac_lat  = 20;
        for (int i = 0; i < 2; i++) begin
            v1a.push_back($urandom_range(0, 65535));
            v1b.push_back($urandom_range(0, 65535));
        end
        for (int i = 0; i < 4; i++) begin
            v2a.push_back($urandom_range(0, 65535));
            v2b.push_back($urandom_range(0, 65535));
        end
        e1 = model(v1a, v1b, 0);
        e2 = model(v2a, v2b, 0);
        push_vec(v1a, v1b);
        push_vec(v2a, v2b);
        while (!out_valid && t < 1000) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_full: in_ready=%b with full FIFO, required 0", in_ready);
        end
        get_frame(g1, 10, 2);
        checks++;
        if (g1 !== e1) begin
            failures++;
            $display("FAIL stall_vec1: got %p required %p", g1, e1);
        end
        get_frame(g2, 1000, 0);
        checks++;
        if (g2 !== e2) begin
            failures++;
            $display("FAIL stall_vec2: got %p required %p", g2, e2);
        end
        checks++;
        if (n_start - n0 != 6) begin
            failures++;
            $display("FAIL stall_starts: mac_start pulses=%0d, required 6", n_start - n0);
        end
    endtask

    task automatic test_rst_mid;
        int unsigned va[$], vb[$];
        frame_t got, exp;
        int t = 0;
        err_mode = 0;
        mac_lat  = 60;
        push_one(9, 9, 0);
        push_one(1, 1, 1);
        while (!mac_start && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, mac_rst, mac_start, out_valid, out_sum, out_exact,
             out_max_err, out_fail_cnt, out_timeout} !== '0) begin
            failures++;
            $display("FAIL rst_mid_outputs: got ready=%b start=%b sum=%h exact=%h, required all zero",
                     in_ready, mac_start, out_sum, out_exact);
        end
        @(negedge clk);
        checks++;
        if ({in_ready, mac_rst, mac_start} !== 3'b000) begin
            failures++;
            $display("FAIL rst_mid_hold: ready/clr/start=%b, required 000", {in_ready, mac_rst, mac_start});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_release: in_ready=%b, required 1", in_ready);
        end
        mac_lat = 1;
        for (int i = 0; i < 3; i++) begin
            va.push_back($urandom_range(0, 65535));
            vb.push_back($urandom_range(0, 65535));
        end
        exp = model(va, vb, 0);
        push_vec(va, vb);
        get_frame(got, 300, 0);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL rst_mid_fresh: got %p required %p", got, exp);
        end
    endtask

    task automatic test_grid;
        int unsigned va[$], vb[$];
        frame_t got, exp;
        err_mode = 0;
        mac_lat  = 0;
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++) begin
                va.push_back(i);
                vb.push_back(j);
            end
        exp = model(va, vb, 0);
        push_vec(va, vb);
        get_frame(got, 300, 0);
        checks++;
        if (got !== exp || got.sum != 40'd14400) begin
            failures++;
            $display("FAIL grid_256: got %p required %p", got, exp);
        end
    endtask

    task automatic test_random;
        int unsigned va[$], vb[$];
        frame_t got, exp;
        int n;
        err_mode = 2;
        for (int v = 0; v < 6; v++) begin
            va.delete();
            vb.delete();
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                va.push_back($urandom_range(0, 65535));
                vb.push_back($urandom_range(0, 65535));
            end
            mac_lat = $urandom_range(0, 3);
            exp = model(va, vb, 0);
            push_vec(va, vb);
            get_frame(got, 500, $urandom_range(0, 3));
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL random_vec%0d: got %p required %p", v, got, exp);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_exact();
        test_error();
        test_timeout();
        test_stall();
        test_rst_mid();
        test_grid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
